// File: rtl/gate_filter_unit.sv
// Selectable AND/OR/XOR/NAND reduction of synchronised ui_in operands, debounced, with edge pulses and rise counter.
// Define GATE_FILTER_RISE_SAT_EN to make the rise counter saturate at 255 instead of wrapping.
module gate_filter_unit #(
  parameter int NUM_IN      = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES - 1);

  // ctl bits: [1:0] opcode, [2] count clear, [3] hold
  logic [SYNC_STAGES-1:0][NUM_IN-1:0] op_sync_q, op_sync_d;
  logic [SYNC_STAGES-1:0][3:0]        ctl_sync_q, ctl_sync_d;

  logic       raw_q, raw_d;
  logic       filt_q, filt_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [7:0] rise_cnt_q, rise_cnt_d;

  logic [NUM_IN-1:0] ops;
  logic [1:0]        opcode;
  logic              clr;
  logic              hold;

  logic unused_inputs;
  assign unused_inputs = ^{ui_in, uio_in[7:4]};

  assign ops    = op_sync_q[SYNC_STAGES-1];
  assign opcode = ctl_sync_q[SYNC_STAGES-1][1:0];
  assign clr    = ctl_sync_q[SYNC_STAGES-1][2];
  assign hold   = ctl_sync_q[SYNC_STAGES-1][3];

  always_comb begin
    op_sync_d     = op_sync_q;
    ctl_sync_d    = ctl_sync_q;
    op_sync_d[0]  = ui_in[NUM_IN-1:0];
    ctl_sync_d[0] = uio_in[3:0];
    for (int i = 1; i < SYNC_STAGES; i++) begin
      op_sync_d[i]  = op_sync_q[i-1];
      ctl_sync_d[i] = ctl_sync_q[i-1];
    end
  end

  always_comb begin
    raw_d = 1'b0;
    case (opcode)
      2'b00:   raw_d = &ops;
      2'b01:   raw_d = |ops;
      2'b10:   raw_d = ^ops;
      default: raw_d = ~&ops;
    endcase
  end

  // Debounce: filt follows raw_q only after DEB_CYCLES consecutive disagreeing edges.
  always_comb begin
    filt_d     = filt_q;
    deb_cnt_d  = deb_cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    rise_cnt_d = rise_cnt_q;
    if (hold) begin
      deb_cnt_d = 8'd0;
    end else if (raw_q == filt_q) begin
      deb_cnt_d = 8'd0;
    end else if (deb_cnt_q == DEB_MAX) begin
      filt_d    = raw_q;
      deb_cnt_d = 8'd0;
      rise_d    = raw_q;
      fall_d    = ~raw_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 8'd1;
    end

    if (clr) begin
      rise_cnt_d = 8'd0;
    end else if (rise_d) begin
`ifdef GATE_FILTER_RISE_SAT_EN
      if (rise_cnt_q != 8'hFF) rise_cnt_d = rise_cnt_q + 8'd1;
`else
      rise_cnt_d = rise_cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sync_q  <= '0;
      ctl_sync_q <= '0;
      raw_q      <= 1'b0;
      filt_q     <= 1'b0;
      deb_cnt_q  <= 8'd0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= 8'd0;
    end else begin
      op_sync_q  <= op_sync_d;
      ctl_sync_q <= ctl_sync_d;
      raw_q      <= raw_d;
      filt_q     <= filt_d;
      deb_cnt_q  <= deb_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign uo_out  = {rise_cnt_q[7:4], raw_q, fall_q, rise_q, filt_q};
  assign uio_out = {rise_cnt_q[3:0], 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_gate_filter_unit.sv
// Directed bench for gate_filter_unit: expectations queued by the driver, checked by a negedge monitor.
module tb_gate_filter_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  gate_filter_unit #(.NUM_IN(2), .DEB_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // scoreboard: entries are {uio_oe, uio_out, uo_out} with a compare mask
  logic [23:0] exp_q[$];
  logic [23:0] msk_q[$];
  string       name_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [23:0] e, m, act;
      string n;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n = name_q.pop_front();
      act = {uio_oe, uio_out, uo_out};
      tests_run++;
      if ((act & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL %s: got %h required %h (mask %h)", n, act & m, e & m, m);
      end
    end
  end

  // driver tasks
  logic [7:0] exp_cnt;
  int         total_rises;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] ops, input logic [1:0] op,
                        input logic clr, input logic hld);
    ui_in  = {6'b0, ops};
    uio_in = {4'b0, hld, clr, op};
  endtask

  task automatic expect_uo(input string n, input logic [7:0] m, input logic [7:0] v);
    exp_q.push_back({16'h0000, v});
    msk_q.push_back({16'h0000, m});
    name_q.push_back(n);
  endtask

  task automatic expect_cnt(input string n);
    exp_q.push_back({8'hF0, exp_cnt[3:0], 4'h0, exp_cnt[7:4], 4'h0});
    msk_q.push_back({8'hFF, 8'hFF, 8'hF0});
    name_q.push_back(n);
  endtask

  task automatic model_rise();
    total_rises++;
`ifdef GATE_FILTER_RISE_SAT_EN
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`else
    exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  // settle helper: apply inputs, wait well past latency, check filt and raw agree with v
  task automatic settle(input string n, input logic [1:0] ops, input logic [1:0] op, input logic v);
    set_in(ops, op, 1'b0, 1'b0);
    cyc(10);
    expect_uo(n, 8'h09, v ? 8'h09 : 8'h00);
  endtask

  initial begin
    exp_cnt = 8'd0;
    total_rises = 0;
    rst_n = 1'b0;
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(3);
    exp_q.push_back(24'hF00000);
    msk_q.push_back(24'hFFFFFF);
    name_q.push_back("reset_state");
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // AND truth table
    settle("and_00", 2'b00, 2'b00, 1'b0);
    settle("and_01", 2'b01, 2'b00, 1'b0);
    settle("and_10", 2'b10, 2'b00, 1'b0);
    settle("and_11", 2'b11, 2'b00, 1'b1);
    model_rise();
    expect_cnt("and_rise_cnt");
    settle("and_back_00", 2'b00, 2'b00, 1'b0);

    // latency and edge pulses
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2);
    expect_uo("lat_raw_edge1", 8'h08, 8'h00);
    cyc(1);
    expect_uo("lat_raw_edge2", 8'h09, 8'h08);
    cyc(3);
    expect_uo("lat_filt_edge5", 8'h03, 8'h00);
    cyc(1);
    model_rise();
    expect_uo("lat_rise_edge6", 8'h0F, 8'h0B);
    expect_cnt("lat_cnt_edge6");
    cyc(1);
    expect_uo("lat_rise_edge7", 8'h0F, 8'h09);
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(7);
    expect_uo("lat_fall_edge6", 8'h0F, 8'h04);
    cyc(1);
    expect_uo("lat_fall_edge7", 8'h0F, 8'h00);
    cyc(4);

    // 3-cycle glitch must not reach filt
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (k == 2) set_in(2'b00, 2'b00, 1'b0, 1'b0);
      expect_uo($sformatf("glitch3_k%0d", k), 8'h0F, (k >= 2 && k <= 4) ? 8'h08 : 8'h00);
    end
    expect_cnt("glitch3_cnt");

    // 4-cycle pulse passes, filt high for 4 cycles
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      logic [7:0] v;
      cyc(1);
      if (k == 3) set_in(2'b00, 2'b00, 1'b0, 1'b0);
      v = 8'h00;
      if (k >= 2 && k <= 5) v[3] = 1'b1;
      if (k >= 6 && k <= 9) v[0] = 1'b1;
      if (k == 6) v[1] = 1'b1;
      if (k == 10) v[2] = 1'b1;
      if (k == 6) model_rise();
      expect_uo($sformatf("glitch4_k%0d", k), 8'h0F, v);
    end
    expect_cnt("glitch4_cnt");

    // opcode modes
    settle("or_01", 2'b01, 2'b01, 1'b1);
    model_rise();
    settle("xor_01", 2'b01, 2'b10, 1'b1);
    settle("nand_01", 2'b01, 2'b11, 1'b1);
    settle("and_01_m", 2'b01, 2'b00, 1'b0);
    settle("xor_11", 2'b11, 2'b10, 1'b0);
    settle("nand_11", 2'b11, 2'b11, 1'b0);
    expect_cnt("modes_cnt");
    settle("and_00_m", 2'b00, 2'b00, 1'b0);

    // counter to 255 then the 256th rise
    while (total_rises < 255) begin
      set_in(2'b11, 2'b00, 1'b0, 1'b0);
      cyc(8);
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      cyc(8);
      model_rise();
    end
    expect_cnt("cnt_255");
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(8);
    model_rise();
    expect_cnt("cnt_256th_rise");
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(10);

    // clear on the rise cycle wins over increment
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (k == 3) set_in(2'b11, 2'b00, 1'b1, 1'b0);
      if (k == 8) set_in(2'b11, 2'b00, 1'b0, 1'b0);
      if (k == 6) begin
        exp_cnt = 8'd0;
        expect_uo("clear_rise_pulse", 8'h0F, 8'h0B);
        expect_cnt("clear_on_rise");
      end
    end
    expect_cnt("clear_after");

    // hold freezes filt during input change
    set_in(2'b11, 2'b00, 1'b0, 1'b1);
    cyc(4);
    set_in(2'b00, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      expect_uo($sformatf("hold_k%0d", k), 8'h07, 8'h01);
    end
    expect_uo("hold_raw_tracks", 8'h08, 8'h00);
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      expect_uo($sformatf("release_k%0d", k), 8'h07,
                (k < 5) ? 8'h01 : ((k == 5) ? 8'h04 : 8'h00));
    end
    expect_cnt("hold_cnt");

    // async reset mid-debounce
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(5);
    expect_uo("pre_reset_raw", 8'h09, 8'h08);
    cyc(1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    exp_q.push_back(24'hF00000);
    msk_q.push_back(24'hFFFFFF);
    name_q.push_back("async_reset");
    set_in(2'b00, 2'b11, 1'b0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (k == 6) begin
        model_rise();
        expect_uo("nand_after_reset_rise", 8'h0F, 8'h0B);
      end
      if (k == 5) expect_uo("nand_after_reset_pre", 8'h0F, 8'h08);
    end
    expect_uo("nand_after_reset_hold", 8'h0F, 8'h09);
    expect_cnt("nand_after_reset_cnt");

    cyc(2);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
